wb_ctrl_pipe: RTL and testbench

Write-back stage for the 5-stage MIPS pipeline. It owns the M/W pipeline register and decodes the W-stage IR into register-file write controls. It also extends load data by byte lane and arbitrates the single RF write port between in-order pipeline results and late results from the multi-cycle MUL/DIV unit. Late results wait in a small FIFO and drain into idle write slots.

---
 rtl/wb_ctrl_pipe.sv | 236 +++++++++++++++++++++++
 tb/tb_wb_ctrl_pipe.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ctrl_pipe.sv
// wb_ctrl_pipe: MIPS write-back stage with a late-result FIFO sharing the RF port.
// Optional starvation guard: define WB_STARVE_GUARD_EN.
module wb_ctrl_pipe #(
   parameter int DW     = 32,
   parameter int RW     = 5,
   parameter int QDEPTH = 2,
   parameter int STARVE = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m_valid,
   output logic          m_ready,
   input  logic [31:0]   m_ir,
   input  logic [DW-1:0] m_ao,
   input  logic [DW-1:0] m_dr,
   input  logic [DW-1:0] m_pc4,
   input  logic          late_valid,
   output logic          late_ready,
   input  logic [RW-1:0] late_addr,
   input  logic [DW-1:0] late_data,
   output logic          w_valid,
   output logic [31:0]   w_ir,
   output logic          rf_we,
   output logic [RW-1:0] rf_a3,
   output logic [DW-1:0] rf_wd
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = $clog2(QDEPTH) + 1;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_RIMM = 6'h01;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_JAL  = 6'h03;
   localparam logic [5:0] OP_LUI  = 6'h0f;
   localparam logic [5:0] OP_LB   = 6'h20;
   localparam logic [5:0] OP_LH   = 6'h21;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_LBU  = 6'h24;
   localparam logic [5:0] OP_LHU  = 6'h25;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_JALR = 6'h09;

   logic          w_valid_q, w_valid_d;
   logic [31:0]   w_ir_q, w_ir_d;
   logic [DW-1:0] w_ao_q, w_ao_d;
   logic [DW-1:0] w_dr_q, w_dr_d;
   logic [DW-1:0] w_pc4_q, w_pc4_d;

   logic [QDEPTH-1:0]         q_vld_q, q_vld_d;
   logic [QDEPTH-1:0][RW-1:0] q_addr_q, q_addr_d;
   logic [QDEPTH-1:0][DW-1:0] q_data_q, q_data_d;
   logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]             cnt_q, cnt_d;

   logic [5:0]    op, fn;
   logic          is_jal, is_j, is_jr, is_jalr;
   logic          is_br, is_st, is_ld, is_cali, is_lui;
   logic [1:0]    lane;
   logic [7:0]    ld_b;
   logic [15:0]   ld_h;
   logic [DW-1:0] ld_ext;
   logic [RW-1:0] pa3;
   logic [DW-1:0] pwd;
   logic          pw;

   logic          found, grant, push;
   logic [CW-1:0] k, pop_n;
   logic [PW-1:0] idx, head_idx;

   assign op      = w_ir_q[31:26];
   assign fn      = w_ir_q[5:0];
   assign is_jal  = op == OP_JAL;
   assign is_j    = op == OP_J;
   assign is_jr   = (op == OP_R) && (fn == FN_JR);
   assign is_jalr = (op == OP_R) && (fn == FN_JALR);
   assign is_br   = (op == OP_RIMM) || (op inside {[6'h04:6'h07]});
   assign is_st   = op inside {6'h28, 6'h29, 6'h2b};
   assign is_ld   = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
   assign is_cali = op inside {[6'h08:6'h0e]};
   assign is_lui  = op == OP_LUI;
   assign lane    = w_ao_q[1:0];

   always_comb begin
      unique case (lane)
         2'd0:    ld_b = w_dr_q[7:0];
         2'd1:    ld_b = w_dr_q[15:8];
         2'd2:    ld_b = w_dr_q[23:16];
         default: ld_b = w_dr_q[31:24];
      endcase
      ld_h = lane[1] ? w_dr_q[31:16] : w_dr_q[15:0];
      case (op)
         OP_LB:   ld_ext = {{(DW-8){ld_b[7]}}, ld_b};
         OP_LBU:  ld_ext = {{(DW-8){1'b0}}, ld_b};
         OP_LH:   ld_ext = {{(DW-16){ld_h[15]}}, ld_h};
         OP_LHU:  ld_ext = {{(DW-16){1'b0}}, ld_h};
         default: ld_ext = w_dr_q;
      endcase
   end

   always_comb begin
      if (is_jal)                       pa3 = RW'(31);
      else if (is_cali || is_lui || is_ld) pa3 = RW'(w_ir_q[20:16]);
      else                              pa3 = RW'(w_ir_q[15:11]);
      if (is_jal || is_jalr) pwd = w_pc4_q;
      else if (is_ld)        pwd = ld_ext;
      else                   pwd = w_ao_q;
   end

   assign pw = w_valid_q && !(is_br || is_st || is_j || is_jr) && (pa3 != '0);

   // Oldest live entry; killed entries ahead of it are dropped with it.
   always_comb begin
      found = 1'b0;
      k     = '0;
      idx   = '0;
      for (int i = 0; i < QDEPTH; i++) begin
         idx = rd_ptr_q + PW'(i);
         if (!found && (CW'(i) < cnt_q) && q_vld_q[idx]) begin
            found = 1'b1;
            k     = CW'(i);
         end
      end
   end

   assign head_idx   = rd_ptr_q + PW'(k);
   assign grant      = !pw && found;
   assign late_ready = cnt_q != CW'(QDEPTH);
   assign push       = late_valid && late_ready && (late_addr != '0);

   always_comb begin
      if (grant)      pop_n = k + CW'(1);
      else if (found) pop_n = k;
      else            pop_n = cnt_q;
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q + PW'(pop_n);
      wr_ptr_d = wr_ptr_q + PW'(push);
      cnt_d    = cnt_q - pop_n + CW'(push);
      q_vld_d  = q_vld_q;
      q_addr_d = q_addr_q;
      q_data_d = q_data_q;
      for (int i = 0; i < QDEPTH; i++) begin
         if (pw && (q_addr_q[i] == pa3)) q_vld_d[i] = 1'b0;
      end
      if (push) begin
         q_vld_d[wr_ptr_q]  = 1'b1;
         q_addr_d[wr_ptr_q] = late_addr;
         q_data_d[wr_ptr_q] = late_data;
      end
   end

   always_comb begin
      w_valid_d = m_valid && m_ready;
      w_ir_d    = w_ir_q;
      w_ao_d    = w_ao_q;
      w_dr_d    = w_dr_q;
      w_pc4_d   = w_pc4_q;
      if (m_valid && m_ready) begin
         w_ir_d  = m_ir;
         w_ao_d  = m_ao;
         w_dr_d  = m_dr;
         w_pc4_d = m_pc4;
      end
   end

   always_comb begin
      rf_we = 1'b0;
      rf_a3 = '0;
      rf_wd = '0;
      if (pw) begin
         rf_we = 1'b1;
         rf_a3 = pa3;
         rf_wd = pwd;
      end else if (grant) begin
         rf_we = 1'b1;
         rf_a3 = q_addr_q[head_idx];
         rf_wd = q_data_q[head_idx];
      end
   end

`ifdef WB_STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE) + 1;

   logic [SW-1:0] starve_q, starve_d;

   always_comb begin
      if (!found || grant)               starve_d = '0;
      else if (starve_q == SW'(STARVE-1)) starve_d = '0;
      else                               starve_d = starve_q + SW'(1);
   end

   assign m_ready = starve_q != SW'(STARVE-1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) starve_q <= '0;
      else        starve_q <= starve_d;
   end
`else
   assign m_ready = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_valid_q <= 1'b0;
         w_ir_q    <= '0;
         w_ao_q    <= '0;
         w_dr_q    <= '0;
         w_pc4_q   <= '0;
         q_vld_q   <= '0;
         q_addr_q  <= '0;
         q_data_q  <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         cnt_q     <= '0;
      end else begin
         w_valid_q <= w_valid_d;
         w_ir_q    <= w_ir_d;
         w_ao_q    <= w_ao_d;
         w_dr_q    <= w_dr_d;
         w_pc4_q   <= w_pc4_d;
         q_vld_q   <= q_vld_d;
         q_addr_q  <= q_addr_d;
         q_data_q  <= q_data_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         cnt_q     <= cnt_d;
      end
   end

   assign w_valid = w_valid_q;
   assign w_ir    = w_ir_q;

endmodule

// File: tb/tb_wb_ctrl_pipe.sv
// tb_wb_ctrl_pipe: directed and random checks of wb_ctrl_pipe
// against a queue-based reference model.
module tb_wb_ctrl_pipe;

   localparam int QDEPTH = 2;
   localparam int STARVE = 4;

   logic        clk;
   logic        rst_n;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_ir, m_ao, m_dr, m_pc4;
   logic        late_valid;
   logic        late_ready;
   logic [4:0]  late_addr;
   logic [31:0] late_data;
   logic        w_valid;
   logic [31:0] w_ir;
   logic        rf_we;
   logic [4:0]  rf_a3;
   logic [31:0] rf_wd;

   wb_ctrl_pipe #(
      .DW(32), .RW(5), .QDEPTH(QDEPTH), .STARVE(STARVE)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .m_valid(m_valid), .m_ready(m_ready),
      .m_ir(m_ir), .m_ao(m_ao), .m_dr(m_dr), .m_pc4(m_pc4),
      .late_valid(late_valid), .late_ready(late_ready),
      .late_addr(late_addr), .late_data(late_data),
      .w_valid(w_valid), .w_ir(w_ir),
      .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
      bit          live;
   } ent_t;

   ent_t        lq[$];
   bit          mwv;
   logic [31:0] mir, mao, mdr, mpc4;
   int          sc;
   int          n_chk;
   int          n_bad;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] r_ins(input int rs, rt, rd,
                                         input logic [5:0] fn);
      r_ins = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op,
                                         input int rs, rt,
                                         input logic [15:0] imm);
      i_ins = {op, 5'(rs), 5'(rt), imm};
   endfunction

   // Reference decode, straight from the instruction semantics.
   function automatic void ref_dec(input bit v, input logic [31:0] ir,
                                   input logic [31:0] ao, dr, pc4,
                                   output bit wr, output logic [4:0] a3,
                                   output logic [31:0] wd);
      int op, fn;
      bit ld, nowr;
      logic [31:0] b, h;
      op   = int'(ir[31:26]);
      fn   = int'(ir[5:0]);
      ld   = op == 32 || op == 33 || op == 35 || op == 36 || op == 37;
      nowr = op == 1 || (op >= 4 && op <= 7) || op == 2 ||
             op == 40 || op == 41 || op == 43 || (op == 0 && fn == 8);
      if (op == 3)                         a3 = 5'd31;
      else if ((op >= 8 && op <= 15) || ld) a3 = ir[20:16];
      else                                 a3 = ir[15:11];
      b = (dr >> (8 * int'(ao[1:0]))) & 32'hFF;
      h = ao[1] ? (dr >> 16) : (dr & 32'hFFFF);
      if (op == 3 || (op == 0 && fn == 9)) wd = pc4;
      else if (op == 32) wd = b[7]  ? (b | 32'hFFFF_FF00) : b;
      else if (op == 36) wd = b;
      else if (op == 33) wd = h[15] ? (h | 32'hFFFF_0000) : h;
      else if (op == 37) wd = h;
      else if (op == 35) wd = dr;
      else               wd = ao;
      wr = v && !nowr && a3 != 5'd0;
   endfunction

   task automatic model_reset();
      lq.delete();
      mwv  = 0;
      mir  = '0;
      mao  = '0;
      mdr  = '0;
      mpc4 = '0;
      sc   = 0;
   endtask

   task automatic step(input bit mv, input logic [31:0] ir, ao, dr, pc4,
                       input bit lv, input logic [4:0] la,
                       input logic [31:0] ld);
      bit          pw, mr, lr;
      logic [4:0]  a3;
      logic [31:0] wd;
      int          f;
      @(negedge clk);
      m_valid    = mv;
      m_ir       = ir;
      m_ao       = ao;
      m_dr       = dr;
      m_pc4      = pc4;
      late_valid = lv;
      late_addr  = la;
      late_data  = ld;
      #1;
      ref_dec(mwv, mir, mao, mdr, mpc4, pw, a3, wd);
      f = -1;
      foreach (lq[i]) if (f < 0 && lq[i].live) f = i;
`ifdef WB_STARVE_GUARD_EN
      mr = sc != STARVE - 1;
`else
      mr = 1;
`endif
      lr = lq.size() < QDEPTH;
      check("w_valid", 32'(w_valid), 32'(mwv));
      check("w_ir", w_ir, mir);
      check("m_ready", 32'(m_ready), 32'(mr));
      check("late_ready", 32'(late_ready), 32'(lr));
      if (pw) begin
         check("rf_we", 32'(rf_we), 32'd1);
         check("rf_a3", 32'(rf_a3), 32'(a3));
         check("rf_wd", rf_wd, wd);
      end else if (f >= 0) begin
         check("rf_we", 32'(rf_we), 32'd1);
         check("rf_a3_late", 32'(rf_a3), 32'(lq[f].a));
         check("rf_wd_late", rf_wd, lq[f].d);
      end else begin
         check("rf_we", 32'(rf_we), 32'd0);
         check("rf_a3_idle", 32'(rf_a3), 32'd0);
         check("rf_wd_idle", rf_wd, 32'd0);
      end
`ifdef WB_STARVE_GUARD_EN
      if (f < 0 || !pw)      sc = 0;
      else if (sc == STARVE - 1) sc = 0;
      else                   sc++;
`endif
      if (!pw && f >= 0) for (int j = 0; j <= f; j++) void'(lq.pop_front());
      else if (f >= 0)   for (int j = 0; j < f; j++) void'(lq.pop_front());
      else               lq.delete();
      if (pw) foreach (lq[i]) if (lq[i].a == a3) lq[i].live = 0;
      if (lv && lr && la != 5'd0) lq.push_back('{la, ld, 1'b1});
      mwv = mv && mr;
      if (mwv) begin
         mir  = ir;
         mao  = ao;
         mdr  = dr;
         mpc4 = pc4;
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      for (int j = 0; j < n; j++) step(0, '0, '0, '0, '0, 0, '0, '0);
   endtask

   function automatic logic [31:0] rnd_ins();
      int rs, rt, rd;
      rs = $urandom_range(0, 31);
      rt = $urandom_range(0, 7);
      rd = $urandom_range(0, 7);
      case ($urandom_range(0, 13))
         0:  return r_ins(rs, rt, rd, 6'h21);
         1:  return r_ins(rs, 0, 0, 6'h08);
         2:  return r_ins(rs, 0, rd, 6'h09);
         3:  return {6'h02, 26'($urandom)};
         4:  return {6'h03, 26'($urandom)};
         5:  return i_ins(6'h04, rs, rt, 16'($urandom));
         6:  return i_ins(6'h2b, rs, rt, 16'($urandom));
         7:  return i_ins(6'h09, rs, rt, 16'($urandom));
         8:  return i_ins(6'h0f, 0, rt, 16'($urandom));
         9:  return i_ins(6'h20, rs, rt, 16'($urandom));
         10: return i_ins(6'h24, rs, rt, 16'($urandom));
         11: return i_ins(6'h21, rs, rt, 16'($urandom));
         12: return i_ins(6'h25, rs, rt, 16'($urandom));
         default: return i_ins(6'h23, rs, rt, 16'($urandom));
      endcase
   endfunction

   initial begin
      n_chk      = 0;
      n_bad      = 0;
      rst_n      = 1'b0;
      m_valid    = 1'b0;
      m_ir       = '0;
      m_ao       = '0;
      m_dr       = '0;
      m_pc4      = '0;
      late_valid = 1'b0;
      late_addr  = '0;
      late_data  = '0;
      model_reset();
      #12;
      check("rst_w_valid", 32'(w_valid), 32'd0);
      check("rst_w_ir", w_ir, 32'd0);
      check("rst_rf_we", 32'(rf_we), 32'd0);
      check("rst_late_ready", 32'(late_ready), 32'd1);
      check("rst_m_ready", 32'(m_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      step(1, i_ins(6'h20, 1, 2, 16'h3), 32'h1003, 32'h80FF_1234, 0, 0, 0, 0);
      #1;
      check("lb_we", 32'(rf_we), 32'd1);
      check("lb_a3", 32'(rf_a3), 32'd2);
      check("lb_wd", rf_wd, 32'hFFFF_FF80);
      step(1, i_ins(6'h24, 1, 2, 16'h3), 32'h1003, 32'h80FF_1234, 0, 0, 0, 0);
      #1;
      check("lbu_wd", rf_wd, 32'h0000_0080);
      step(1, i_ins(6'h21, 1, 2, 16'h2), 32'h1002, 32'h80FF_1234, 0, 0, 0, 0);
      #1;
      check("lh_wd", rf_wd, 32'hFFFF_80FF);
      step(1, {6'h03, 26'h10_0002}, 32'h0, 32'h0, 32'h0040_0008, 0, 0, 0);
      #1;
      check("jal_a3", 32'(rf_a3), 32'd31);
      check("jal_wd", rf_wd, 32'h0040_0008);
      step(1, i_ins(6'h2b, 1, 2, 16'h4), 32'h4, 0, 0, 0, 0, 0);
      #1;
      check("sw_we", 32'(rf_we), 32'd0);
      step(1, i_ins(6'h04, 1, 2, 16'h4), 32'h4, 0, 0, 0, 0, 0);
      #1;
      check("beq_we", 32'(rf_we), 32'd0);
      step(1, r_ins(1, 2, 0, 6'h21), 32'h77, 0, 0, 0, 0, 0);
      #1;
      check("r0_we", 32'(rf_we), 32'd0);
      idle(1);

      step(1, r_ins(1, 2, 7, 6'h21), 32'h1, 0, 0, 1, 5'd9, 32'hAAAA);
      step(1, r_ins(1, 2, 9, 6'h21), 32'h5555, 0, 0, 1, 5'd5, 32'h1234);
      #1;
      check("full_late_ready", 32'(late_ready), 32'd0);
      step(0, '0, '0, '0, '0, 0, '0, '0);
      #1;
      check("kill_we", 32'(rf_we), 32'd1);
      check("kill_a3", 32'(rf_a3), 32'd5);
      check("kill_wd", rf_wd, 32'h1234);
      step(0, '0, '0, '0, '0, 0, '0, '0);
      #1;
      check("drained_we", 32'(rf_we), 32'd0);
      check("drained_late_ready", 32'(late_ready), 32'd1);

      step(1, r_ins(1, 2, 7, 6'h21), 32'h1, 0, 0, 1, 5'd3, 32'h33);
      step(1, r_ins(1, 2, 6, 6'h21), 32'h2, 0, 0, 1, 5'd4, 32'h44);
      #3;
      rst_n = 1'b0;
      m_valid    = 1'b0;
      late_valid = 1'b0;
      #1;
      check("arst_rf_we", 32'(rf_we), 32'd0);
      check("arst_w_valid", 32'(w_valid), 32'd0);
      check("arst_late_ready", 32'(late_ready), 32'd1);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 3) != 0, rnd_ins(), $urandom, $urandom,
              $urandom, $urandom_range(0, 2) == 0,
              5'($urandom_range(0, 7)), $urandom);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
